// File: rtl/compile_pkg.sv
// Shared constants for the compile dispatcher: state codes, WIM encodings,
// default engine capability masks and engine index names.
package compile_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_ARM    = 3'd1;
   localparam state_t S_LAUNCH = 3'd2;
   localparam state_t S_RUN    = 3'd3;
   localparam state_t S_WRITE  = 3'd4;
   localparam state_t S_FAULT  = 3'd5;

   localparam logic [1:0] WIM_OFF = 2'h0;
   localparam logic [1:0] WIM_WR  = 2'h3;

   // Bit e of each mask describes engine e.
   localparam logic [3:0] STREAM_MASK_DEF = 4'b1110;
   localparam logic [3:0] LDSR_MASK_DEF   = 4'b0101;
   localparam logic [3:0] SCPU_MASK_DEF   = 4'b0010;

   localparam int ENG_VM   = 0;
   localparam int ENG_OC   = 1;
   localparam int ENG_IOAC = 2;

endpackage

// File: rtl/compile_watchdog.sv
// RUN-phase watchdog: counts stalled RUN cycles and flags the cycle that
// reaches TMO_CYC. Only instantiated when COMPILE_WATCHDOG_EN is defined.
module compile_watchdog #(
   parameter int TMO_CYC = 255
) (
   input  logic Clk,
   input  logic Rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int CW = $clog2(TMO_CYC + 1);
   localparam logic [CW-1:0] LAST = CW'(TMO_CYC - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge Clk) begin
      if (Rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != LAST)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // The TMO_CYC-th consecutive RUN cycle is the expiring one.
   assign expired = inc && (cnt == LAST);

endmodule

// File: rtl/compile_dispatcher.sv
// Compile dispatcher: launches one of NUM_ENG engines per request and steers
// the instruction-write path. Optional watchdog under COMPILE_WATCHDOG_EN.
//
// state  | meaning
// IDLE   | waiting for Start; Ready=1
// ARM    | Start seen, waiting for it to fall; engine latched on the fall
// LAUNCH | one-cycle EngStart pulse to the latched engine
// RUN    | engine working; Ready pulse or first GiveIns ends this phase
// WRITE  | streaming instructions while GiveIns stays high
// FAULT  | watchdog expired; held until Start (watchdog builds only)
module compile_dispatcher
   import compile_pkg::*;
#(
   parameter int                   NUM_ENG     = 4,
   parameter int                   SEL_W       = 4,
   parameter int                   WIM_W       = 2,
   parameter logic [WIM_W-1:0]     WIM_WR      = WIM_W'(compile_pkg::WIM_WR),
   parameter logic [NUM_ENG-1:0]   STREAM_MASK = NUM_ENG'(STREAM_MASK_DEF),
   parameter logic [NUM_ENG-1:0]   LDSR_MASK   = NUM_ENG'(LDSR_MASK_DEF),
   parameter logic [NUM_ENG-1:0]   SCPU_MASK   = NUM_ENG'(SCPU_MASK_DEF),
   parameter int                   CNT_W       = 10,
   parameter int                   TMO_CYC     = 255
) (
   input  logic                         Clk,
   input  logic                         Rst,
   input  logic                         Start,
   input  logic [SEL_W-1:0]             Sel,
   input  logic [NUM_ENG-1:0]           EngReady,
   input  logic [NUM_ENG-1:0]           EngGiveIns,
   output logic [NUM_ENG-1:0]           EngStart,
   output logic                         Ready,
   output logic                         Busy,
   output logic                         LdSR,
   output logic [WIM_W-1:0]             WIM,
   output logic                         CLNO,
   output logic                         SCPUIns,
   output logic [$clog2(NUM_ENG)-1:0]   ActEng,
   output logic [CNT_W-1:0]             InsCnt,
   output logic                         Err,
   output logic [2:0]                   State
);

   localparam int AW = $clog2(NUM_ENG);
   localparam logic [SEL_W-1:0] TOP_SEL = SEL_W'(NUM_ENG - 1);
   localparam logic [AW-1:0]    TOP_ENG = AW'(NUM_ENG - 1);

   state_t           state, state_nxt;
   logic [AW-1:0]    act_eng;
   logic [CNT_W-1:0] ins_cnt;
   logic             err;
   logic             give, rdy, strm, wr_cyc, wd_expired;

   assign give   = EngGiveIns[act_eng];
   assign rdy    = EngReady[act_eng];
   assign strm   = STREAM_MASK[act_eng];
   assign wr_cyc = ((state == S_RUN) && strm && give) || ((state == S_WRITE) && give);

`ifdef COMPILE_WATCHDOG_EN
   compile_watchdog #(
      .TMO_CYC (TMO_CYC)
   ) u_watchdog (
      .Clk     (Clk),
      .Rst     (Rst),
      .clr     ((state == S_LAUNCH) || wr_cyc),
      .inc     (state == S_RUN),
      .expired (wd_expired)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         err <= 1'b0;
      end else if ((state == S_RUN) && (state_nxt == S_FAULT)) begin
         err <= 1'b1;
      end else if ((state == S_FAULT) && Start) begin
         err <= 1'b0;
      end
   end
`else
   logic unused_tmo;
   assign unused_tmo = (TMO_CYC == 0);
   assign wd_expired = 1'b0;
   assign err        = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (Start) state_nxt = S_ARM;
         S_ARM:    if (!Start) state_nxt = S_LAUNCH;
         S_LAUNCH: state_nxt = S_RUN;
         S_RUN: begin
            // Stream engines finish through WRITE; the others on their Ready pulse.
            if (strm ? give : rdy) begin
               state_nxt = strm ? S_WRITE : S_IDLE;
            end else if (wd_expired) begin
               state_nxt = S_FAULT;
            end
         end
         S_WRITE:  if (!give) state_nxt = S_IDLE;
`ifdef COMPILE_WATCHDOG_EN
         S_FAULT:  if (Start) state_nxt = S_ARM;
`else
         S_FAULT:  state_nxt = S_IDLE;
`endif
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state   <= S_IDLE;
         act_eng <= '0;
         ins_cnt <= '0;
      end else begin
         state <= state_nxt;
         if ((state == S_ARM) && !Start) begin
            act_eng <= (Sel >= TOP_SEL) ? TOP_ENG : Sel[AW-1:0];
         end
         if ((state_nxt == S_ARM) && (state != S_ARM)) begin
            ins_cnt <= '0;
         end else if (wr_cyc && (ins_cnt != '1)) begin
            ins_cnt <= ins_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      EngStart = '0;
      if (state == S_LAUNCH) EngStart[act_eng] = 1'b1;
`ifdef COMPILE_WATCHDOG_EN
      Ready = (state == S_IDLE);
`else
      Ready = (state == S_IDLE) || (state == S_FAULT);
`endif
      Busy    = !Ready;
      LdSR    = ((state == S_LAUNCH) || (state == S_RUN)) && LDSR_MASK[act_eng];
      SCPUIns = ((state == S_RUN) || (state == S_WRITE)) && SCPU_MASK[act_eng];
      WIM     = wr_cyc ? WIM_WR : WIM_W'(WIM_OFF);
      CLNO    = wr_cyc;
   end

   assign ActEng = act_eng;
   assign InsCnt = ins_cnt;
   assign Err    = err;
   assign State  = state;

endmodule

// File: tb/tb_compile_dispatcher.sv
// Directed bench for compile_dispatcher with a phase-level reference model
// compared on every cycle, plus literal spot checks.
module tb_compile_dispatcher;
   import compile_pkg::*;

   localparam int N    = 4;
   localparam int CW   = 10;
   localparam int TMO  = 8;
   localparam int SATV = (1 << CW) - 1;
   localparam logic [3:0] M_STRM = 4'b1110;
   localparam logic [3:0] M_LDSR = 4'b0101;
   localparam logic [3:0] M_SCPU = 4'b0010;

   logic          Clk = 1'b0;
   logic          Rst, Start;
   logic [3:0]    Sel;
   logic [N-1:0]  EngReady, EngGiveIns;
   logic [N-1:0]  EngStart;
   logic          Ready, Busy, LdSR, CLNO, SCPUIns, Err;
   logic [1:0]    WIM;
   logic [1:0]    ActEng;
   logic [CW-1:0] InsCnt;
   logic [2:0]    State;

   always #5 Clk = ~Clk;

   compile_dispatcher #(.TMO_CYC(TMO)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Sel(Sel),
      .EngReady(EngReady), .EngGiveIns(EngGiveIns), .EngStart(EngStart),
      .Ready(Ready), .Busy(Busy), .LdSR(LdSR), .WIM(WIM), .CLNO(CLNO),
      .SCPUIns(SCPUIns), .ActEng(ActEng), .InsCnt(InsCnt), .Err(Err), .State(State)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: request phase, chosen engine, written count, stall time.
   typedef enum int {P_IDLE, P_ARM, P_LAUNCH, P_RUN, P_WRITE, P_FAULT} ph_t;
   ph_t m_ph   = P_IDLE;
   int  m_eng  = 0;
   int  m_cnt  = 0;
   int  m_wd   = 0;
   bit  m_err  = 1'b0;
   bit  m_live = 1'b0;

   function automatic int ph_code(input ph_t p);
      case (p)
         P_IDLE:   return 0;
         P_ARM:    return 1;
         P_LAUNCH: return 2;
         P_RUN:    return 3;
         P_WRITE:  return 4;
         default:  return 5;
      endcase
   endfunction

   always @(posedge Clk) begin
      if (Rst) begin
         m_ph <= P_IDLE; m_eng <= 0; m_cnt <= 0; m_wd <= 0; m_err <= 1'b0; m_live <= 1'b1;
      end else begin
         case (m_ph)
            P_IDLE: if (Start) begin m_ph <= P_ARM; m_cnt <= 0; end
            P_ARM: if (!Start) begin
               m_eng <= (int'(Sel) > N - 1) ? N - 1 : int'(Sel);
               m_ph  <= P_LAUNCH;
            end
            P_LAUNCH: begin m_ph <= P_RUN; m_wd <= 0; end
            P_RUN: begin
               if (M_STRM[m_eng] && EngGiveIns[m_eng]) begin
                  m_ph <= P_WRITE; m_cnt <= (m_cnt < SATV) ? m_cnt + 1 : SATV;
               end else if (!M_STRM[m_eng] && EngReady[m_eng]) begin
                  m_ph <= P_IDLE;
               end else begin
`ifdef COMPILE_WATCHDOG_EN
                  if (m_wd + 1 >= TMO) begin m_ph <= P_FAULT; m_err <= 1'b1; end
                  else m_wd <= m_wd + 1;
`endif
               end
            end
            P_WRITE: begin
               if (EngGiveIns[m_eng]) m_cnt <= (m_cnt < SATV) ? m_cnt + 1 : SATV;
               else m_ph <= P_IDLE;
            end
            default: if (Start) begin m_ph <= P_ARM; m_err <= 1'b0; m_cnt <= 0; end
         endcase
      end
   end

   always @(negedge Clk) begin : compare
      logic       wr;
      logic [3:0] e_start;
      if (m_live) begin
         wr = ((m_ph == P_RUN) && M_STRM[m_eng] && EngGiveIns[m_eng]) ||
              ((m_ph == P_WRITE) && EngGiveIns[m_eng]);
         e_start = '0;
         if (m_ph == P_LAUNCH) e_start[m_eng] = 1'b1;
         chk("state",    State,    ph_code(m_ph));
         chk("engstart", EngStart, e_start);
         chk("ready",    Ready,    m_ph == P_IDLE);
         chk("busy",     Busy,     m_ph != P_IDLE);
         chk("ldsr",     LdSR,     ((m_ph == P_LAUNCH) || (m_ph == P_RUN)) && M_LDSR[m_eng]);
         chk("scpu",     SCPUIns,  ((m_ph == P_RUN) || (m_ph == P_WRITE)) && M_SCPU[m_eng]);
         chk("wim",      WIM,      wr ? 3 : 0);
         chk("clno",     CLNO,     wr);
         chk("acteng",   ActEng,   m_eng);
         chk("inscnt",   InsCnt,   m_cnt);
         chk("err",      Err,      m_err);
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic sample();
      @(negedge Clk);
   endtask

   task automatic launch(input logic [3:0] s);
      Sel = s; Start = 1'b1;
      tick();
      Start = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int n_clno;
      Rst = 1'b1; Start = 1'b1; Sel = 4'(ENG_VM); EngReady = '0; EngGiveIns = '0;
      tick(); tick();
      sample();
      chk("rst_state", State, 0);
      chk("rst_ready", Ready, 1);
      chk("rst_busy",  Busy, 0);
      chk("rst_cnt",   InsCnt, 0);
      chk("rst_start", EngStart, 0);
      Rst = 1'b0;
      tick(); sample();
      chk("arm_after_rst", State, 1);

      // Non-stream engine 0
      Start = 1'b0;
      tick(); sample();
      chk("vm_engstart", EngStart, 4'b0001);
      chk("vm_ldsr_launch", LdSR, 1);
      tick(); sample();
      chk("vm_ldsr_run", LdSR, 1);
      chk("vm_pulse_once", EngStart, 0);
      tick(); tick();
      EngReady = 4'b0001;
      tick(); EngReady = '0; sample();
      chk("vm_ready", Ready, 1);
      chk("vm_cnt", InsCnt, 0);

      // Stream engine 1, five instructions
      launch(4'(ENG_OC));
      sample();
      chk("oc_engstart", EngStart, 4'b0010);
      tick(); tick();
      EngGiveIns = 4'b0010;
      n_clno = 0;
      for (int i = 0; i < 5; i++) begin
         sample();
         if (CLNO) n_clno++;
         chk("oc_scpu", SCPUIns, 1);
         chk("oc_wim", WIM, 3);
         tick();
      end
      EngGiveIns = '0;
      sample(); if (CLNO) n_clno++;
      tick(); sample();
      chk("oc_clno_cycles", n_clno, 5);
      chk("oc_cnt", InsCnt, 5);
      chk("oc_idle", State, 0);

      // Out-of-range select maps to engine 3; engine 0 noise and Start ignored
      launch(4'd9);
      sample();
      chk("oor_acteng", ActEng, 3);
      chk("oor_engstart", EngStart, 4'b1000);
      tick();
      Start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         EngGiveIns[0] = i[0];
         EngReady[0]   = ~i[0];
         tick();
      end
      Start = 1'b0; EngGiveIns = '0; EngReady = '0;
      sample();
      chk("oor_still_run", State, 3);
      EngGiveIns = 4'b1000;
      tick(); tick(); tick();
      EngGiveIns = '0;
      tick(); sample();
      chk("oor_cnt", InsCnt, 3);
      chk("oor_idle", State, 0);

      // Reset in the second WRITE cycle
      launch(4'(ENG_IOAC));
      tick();
      EngGiveIns = 4'b0100;
      tick(); tick();
      Rst = 1'b1;
      tick(); sample();
      chk("mid_rst_state", State, 0);
      chk("mid_rst_wim", WIM, 0);
      chk("mid_rst_clno", CLNO, 0);
      chk("mid_rst_cnt", InsCnt, 0);
      Rst = 1'b0; EngGiveIns = '0;
      tick();

      // Counter saturation on engine 3
      launch(4'd3);
      tick();
      EngGiveIns = 4'b1000;
      repeat (1030) tick();
      EngGiveIns = '0;
      sample();
      chk("sat_cnt", InsCnt, 10'h3FF);
      tick(); sample();
      chk("sat_idle", State, 0);

      // Stalled RUN on engine 0
      launch(4'(ENG_VM));
      tick();
      repeat (10) tick();
      sample();
`ifdef COMPILE_WATCHDOG_EN
      chk("wd_fault_state", State, 5);
      chk("wd_err", Err, 1);
      chk("wd_busy", Busy, 1);
      Start = 1'b1;
      tick(); sample();
      chk("wd_clear_err", Err, 0);
      chk("wd_rearm", State, 1);
      Start = 1'b0;
      tick(); tick();
`else
      chk("nowd_state", State, 3);
      chk("nowd_err", Err, 0);
`endif
      EngReady = 4'b0001;
      tick(); EngReady = '0; sample();
      chk("final_ready", Ready, 1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
